// File: rtl/regbank_ctrl.sv
// regbank_ctrl: write-port arbiter and sequencer for the 16x16 register bank.
//
// Two writeback requesters (A = ALU, B = memory load) share the bank's single
// write port under round-robin arbitration. The block also gates the bank's
// read strobe and runs a hardware clear sweep that zeroes every register.
// All rb_* outputs come straight from flops.
//
// Ports:
//   clock, reset_n         system clock, asynchronous active-low reset
//   clr_req / clr_busy     start a clear sweep / sweep writes in progress
//   a_valid/addr/data      requester A write request, a_ready = accepted
//   b_valid/addr/data      requester B write request, b_ready = accepted
//   rd_valid / rd_ready    datapath read request / read permitted
//   rb_in_write, rb_ender,
//   rb_data, rb_in_read    registered drive to the register bank
module regbank_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              rd_valid,
    output logic              rd_ready,
    output logic              rb_in_write,
    output logic [ADDR_W-1:0] rb_ender,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_in_read
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NREG - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;      // 0: A wins contention, 1: B wins
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              in_write_d;
    logic [ADDR_W-1:0] ender_d;
    logic [DATA_W-1:0] data_d;
    logic              in_read_d;
    logic              busy_d;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        rd_ready   = 1'b0;
        in_write_d = 1'b0;
        ender_d    = rb_ender;  // address/data hold when nothing is written
        data_d     = rb_data;
        in_read_d  = 1'b0;
        busy_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end else begin
                    rd_ready  = 1'b1;
                    in_read_d = rd_valid;
                    if (a_valid && b_valid) begin
                        if (ptr_q) begin
                            b_ready = 1'b1;
                        end else begin
                            a_ready = 1'b1;
                        end
                        // Loser of a contended grant gets priority next time.
                        ptr_d = ~ptr_q;
                    end else begin
                        a_ready = a_valid;
                        b_ready = b_valid;
                    end
                    if (a_ready) begin
                        in_write_d = 1'b1;
                        ender_d    = a_addr;
                        data_d     = a_data;
                    end else if (b_ready) begin
                        in_write_d = 1'b1;
                        ender_d    = b_addr;
                        data_d     = b_data;
                    end
                end
            end
            StClear: begin
                // busy is registered so it lines up with the registered sweep writes.
                busy_d     = 1'b1;
                in_write_d = 1'b1;
                ender_d    = cnt_q;
                data_d     = '0;
                cnt_d      = cnt_q + ADDR_W'(1);
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            rb_in_write <= 1'b0;
            rb_ender    <= '0;
            rb_data     <= '0;
            rb_in_read  <= 1'b0;
            clr_busy    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rb_in_write <= in_write_d;
            rb_ender    <= ender_d;
            rb_data     <= data_d;
            rb_in_read  <= in_read_d;
            clr_busy    <= busy_d;
        end
    end

endmodule
